// File: rtl/div_arbiter.sv
// Round-robin front end for one shared multi-cycle signed divider: grants one
// requester at a time, launches the divide, routes the result back.
module div_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DIVIDEND_WIDTH = 64,
  parameter int DIVISOR_WIDTH  = 32,
  parameter int TIMEOUT        = 128
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0]    req_dividend,
  input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]     req_divisor,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [DIVIDEND_WIDTH-1:0]            rsp_quotient,
  output logic [DIVISOR_WIDTH-1:0]             rsp_remainder,
  output logic                                 rsp_overflow,
  output logic                                 rsp_timeout,
  output logic                                 busy,
  output logic                                 div_valid_in,
  output logic [DIVIDEND_WIDTH-1:0]            div_dividend,
  output logic [DIVISOR_WIDTH-1:0]             div_divisor,
  input  logic [DIVIDEND_WIDTH-1:0]            div_quotient,
  input  logic [DIVISOR_WIDTH-1:0]             div_remainder,
  input  logic                                 div_overflow,
  input  logic                                 div_valid_out
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                      state;
  logic [GW-1:0]               last_grant;
  logic [GW-1:0]               grant;
  logic [GW-1:0]               sel;
  logic                        found;
  int                          scan_idx;
  logic [WW-1:0]               watchdog;
  logic [WW-1:0]               wd_next;
  logic [DIVIDEND_WIDTH-1:0]   op_dividend;
  logic [DIVISOR_WIDTH-1:0]    op_divisor;
  logic [DIVIDEND_WIDTH-1:0]   sel_dividend;
  logic [DIVISOR_WIDTH-1:0]    sel_divisor;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] g);
    logic [NUM_REQ-1:0] r;
    r    = '0;
    r[g] = 1'b1;
    return r;
  endfunction

  // Search starts just past the last served requester so a requester that
  // holds req_valid high cannot starve the others.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    scan_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (int'(last_grant) + 1 + k) % NUM_REQ;
      if (!found && req_valid[scan_idx]) begin
        found = 1'b1;
        sel   = GW'(scan_idx);
      end
    end
  end

  assign sel_dividend = req_dividend[int'(sel)*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
  assign sel_divisor  = req_divisor[int'(sel)*DIVISOR_WIDTH +: DIVISOR_WIDTH];
  assign wd_next      = watchdog + 1'b1;

  always_comb begin
    req_ready = '0;
    if (reset && state == IDLE && found)
      req_ready = onehot(sel);
  end

  assign busy         = (state != IDLE);
  assign div_dividend = op_dividend;
  assign div_divisor  = op_divisor;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last_grant    <= GW'(NUM_REQ - 1);
      grant         <= '0;
      watchdog      <= '0;
      op_dividend   <= '0;
      op_divisor    <= '0;
      rsp_valid     <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_overflow  <= 1'b0;
      rsp_timeout   <= 1'b0;
      div_valid_in  <= 1'b0;
    end else begin
      rsp_valid    <= '0;
      div_valid_in <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant       <= sel;
            op_dividend <= sel_dividend;
            op_divisor  <= sel_divisor;
            // Divide-by-zero is answered locally; the divider is never launched.
            if (sel_divisor == '0) begin
              rsp_quotient  <= '1;
              rsp_remainder <= '0;
              rsp_overflow  <= 1'b1;
              rsp_timeout   <= 1'b0;
              rsp_valid     <= onehot(sel);
              state         <= RESP;
            end else begin
              div_valid_in <= 1'b1;
              state        <= ISSUE;
            end
          end
        end
        ISSUE: begin
          watchdog <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          watchdog <= wd_next;
          if (div_valid_out) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
            rsp_overflow  <= div_overflow;
            rsp_timeout   <= 1'b0;
            rsp_valid     <= onehot(grant);
            state         <= RESP;
          end else if (wd_next == WW'(TIMEOUT - 1)) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_overflow  <= 1'b0;
            rsp_timeout   <= 1'b1;
            rsp_valid     <= onehot(grant);
            state         <= RESP;
          end
        end
        RESP: begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural divider of programmable latency.
module tb_div_arbiter;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [127:0]  req_dividend;
  logic [63:0]   req_divisor;
  logic [1:0]    rsp_valid;
  logic [63:0]   rsp_quotient;
  logic [31:0]   rsp_remainder;
  logic          rsp_overflow;
  logic          rsp_timeout;
  logic          busy;
  logic          div_valid_in;
  logic [63:0]   div_dividend;
  logic [31:0]   div_divisor;
  logic [63:0]   div_quotient;
  logic [31:0]   div_remainder;
  logic          div_overflow;
  logic          div_valid_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // divider model state
  int                 mdl_lat = 8;
  logic               mdl_never = 1'b0;
  logic               mdl_vo = 1'b0;
  logic               inj_vo = 1'b0;
  logic               launched = 1'b0;
  int                 launch_cyc = 0;
  int                 dvi_cnt = 0;
  logic signed [63:0] m_dvd;
  logic signed [31:0] m_dvs;
  logic signed [63:0] m_rem;

  div_arbiter #(.NUM_REQ(2), .DIVIDEND_WIDTH(64), .DIVISOR_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout), .busy(busy),
    .div_valid_in(div_valid_in), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_overflow(div_overflow), .div_valid_out(div_valid_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign div_valid_out = mdl_vo | inj_vo;
  assign div_overflow  = 1'b0;

  // Divider: launched by div_valid_in in cycle L, answers in cycle L+mdl_lat.
  always @(negedge clk) begin
    mdl_vo = 1'b0;
    if (!reset) begin
      launched = 1'b0;
    end else begin
      if (div_valid_in) begin
        launched   = 1'b1;
        launch_cyc = cyc;
        m_dvd      = div_dividend;
        m_dvs      = div_divisor;
        dvi_cnt++;
      end
      if (launched && !mdl_never && cyc == launch_cyc + mdl_lat) begin
        mdl_vo        = 1'b1;
        launched      = 1'b0;
        div_quotient  = m_dvd / m_dvs;
        m_rem         = m_dvd % m_dvs;
        div_remainder = m_rem[31:0];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [63:0] dvd, input logic [31:0] dvs);
    req_dividend[i*64 +: 64] = dvd;
    req_divisor[i*32 +: 32]  = dvs;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (rsp_valid == 2'b00 && n < 60);
    if (rsp_valid == 2'b00) begin
      checks++;
      errors++;
      $display("FAIL wait_rsp: no rsp_valid within %0d cycles", n);
    end
  endtask

  logic [1:0]  exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [63:0] exp_q [4] = '{64'd10, 64'hFFFF_FFFF_FFFF_FFFA, 64'd10, 64'hFFFF_FFFF_FFFF_FFFA};
  int t0;
  int bad;
  int dvi0;

  initial begin
    reset = 1'b0;
    req_valid = 2'b00;
    req_dividend = '0;
    req_divisor = '0;
    div_quotient = '0;
    div_remainder = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_div_valid_in", div_valid_in, 0);
    check("rst_div_dividend", div_dividend, 0);
    check("rst_quotient", rsp_quotient, 0);
    step(); step();
    reset = 1'b1;
    step();

    // basic divide, D=8
    set_req(0, 64'd100, 32'd7);
    req_valid = 2'b01;
    #1;
    check("t1_ready", req_ready, 2'b01);
    check("t1_busy_idle", busy, 0);
    t0 = cyc;
    step();
    req_valid = 2'b00;
    check("t1_launch", div_valid_in, 1);
    check("t1_launch_cyc", cyc - t0, 1);
    check("t1_div_dividend", div_dividend, 100);
    check("t1_div_divisor", div_divisor, 7);
    wait_rsp();
    check("t1_latency", cyc - t0, 10);
    check("t1_rsp_valid", rsp_valid, 2'b01);
    check("t1_quot", rsp_quotient, 14);
    check("t1_rem", rsp_remainder, 2);
    check("t1_ovf", rsp_overflow, 0);
    check("t1_tmo", rsp_timeout, 0);
    step();
    check("t1_pulse", rsp_valid, 0);
    step();
    check("t1_hold", rsp_quotient, 14);

    // round-robin alternation with both requesters held high
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    set_req(0, 64'd50, 32'd5);
    set_req(1, -64'sd20, 32'd3);
    req_valid = 2'b11;
    #1;
    check("t2_first_ready", req_ready, 2'b01);
    for (int i = 0; i < 4; i++) begin
      wait_rsp();
      check("t2_grant", rsp_valid, exp_g[i]);
      check("t2_quot", rsp_quotient, exp_q[i]);
      if (i < 3) begin
        step();
        check("t2_gap_busy", busy, 0);
        check("t2_next_ready", req_ready, exp_g[i+1]);
        step();
        check("t2_run_busy", busy, 1);
      end
    end
    req_valid = 2'b00;
    step();

    // divide by zero on requester 1
    dvi0 = dvi_cnt;
    set_req(1, 64'd77, 32'd0);
    req_valid = 2'b10;
    #1;
    check("t3_ready", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    check("t3_rsp_valid", rsp_valid, 2'b10);
    check("t3_quot", rsp_quotient, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t3_rem", rsp_remainder, 0);
    check("t3_ovf", rsp_overflow, 1);
    check("t3_tmo", rsp_timeout, 0);
    check("t3_no_launch", div_valid_in, 0);
    step(); step();
    check("t3_launch_count", dvi_cnt - dvi0, 0);

    // hung divider, watchdog abort, then a stale done strobe
    mdl_never = 1'b1;
    set_req(0, 64'd9, 32'd2);
    req_valid = 2'b01;
    #1;
    t0 = cyc;
    step();
    req_valid = 2'b00;
    wait_rsp();
    check("t4_latency", cyc - t0, 17);
    check("t4_rsp_valid", rsp_valid, 2'b01);
    check("t4_tmo", rsp_timeout, 1);
    check("t4_quot", rsp_quotient, 0);
    check("t4_ovf", rsp_overflow, 0);
    for (int i = 0; i < 5; i++) step();
    inj_vo = 1'b1;
    step();
    inj_vo = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid != 2'b00 || busy) bad++;
      step();
    end
    check("t4_late_ignored", bad, 0);
    check("t4_tmo_held", rsp_timeout, 1);
    mdl_never = 1'b0;

    // reset pulled three cycles into WAIT
    set_req(1, 64'd30, 32'd4);
    req_valid = 2'b10;
    #1;
    check("t5_ready", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    step(); step(); step();
    check("t5_in_wait", busy, 1);
    reset = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_tmo", rsp_timeout, 0);
    check("t5_rst_dividend", div_dividend, 0);
    check("t5_rst_divisor", div_divisor, 0);
    check("t5_rst_rsp_valid", rsp_valid, 0);
    step(); step();
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rsp_valid != 2'b00) bad++;
    end
    check("t5_no_rsp", bad, 0);
    set_req(0, 64'd81, 32'd9);
    req_valid = 2'b11;
    #1;
    check("t5_first_grant", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    wait_rsp();
    check("t5_rsp_valid", rsp_valid, 2'b01);
    check("t5_quot", rsp_quotient, 9);
    step();

    // divider answers in the same cycle the watchdog expires
    mdl_lat = 15;
    set_req(0, -64'sd100, 32'd7);
    req_valid = 2'b01;
    #1;
    t0 = cyc;
    step();
    req_valid = 2'b00;
    wait_rsp();
    check("t6_latency", cyc - t0, 17);
    check("t6_rsp_valid", rsp_valid, 2'b01);
    check("t6_tmo", rsp_timeout, 0);
    check("t6_quot", rsp_quotient, 64'hFFFF_FFFF_FFFF_FFF2);
    check("t6_rem", rsp_remainder, 64'hFFFF_FFFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

endmodule
